// File: rtl/key_schedule_seq_if.sv
// rtl/key_schedule_seq_if.sv - start/key request and round-key handshake bundle
// The round datapath paces key delivery through key_valid/key_ready.
interface key_schedule_seq_if;
  logic        start;
  logic [63:0] key_in;
  logic        key_ready;
  logic        key_valid;
  logic [63:0] round_key;
  logic [3:0]  round_number;
  logic        busy;
  logic        done;

  modport master (
    output start, key_in, key_ready,
    input  key_valid, round_key, round_number, busy, done
  );

  modport slave (
    input  start, key_in, key_ready,
    output key_valid, round_key, round_number, busy, done
  );
endinterface

// File: rtl/key_schedule_seq.sv
// rtl/key_schedule_seq.sv - iterative round-key expansion for 64-bit small-scale AES
// Emits K0..K10 one per accepted handshake; the round key is updated in place.
module key_schedule_seq_sbox (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  always_comb begin
    nib_o = 4'h0;
    case (nib_i)
      4'h0: nib_o = 4'h6;
      4'h1: nib_o = 4'hB;
      4'h2: nib_o = 4'h5;
      4'h3: nib_o = 4'h4;
      4'h4: nib_o = 4'h2;
      4'h5: nib_o = 4'hE;
      4'h6: nib_o = 4'h7;
      4'h7: nib_o = 4'hA;
      4'h8: nib_o = 4'h9;
      4'h9: nib_o = 4'hD;
      4'hA: nib_o = 4'hF;
      4'hB: nib_o = 4'hC;
      4'hC: nib_o = 4'h3;
      4'hD: nib_o = 4'h1;
      4'hE: nib_o = 4'h0;
      4'hF: nib_o = 4'h8;
      default: nib_o = 4'h0;
    endcase
  end
endmodule

module key_schedule_seq #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  key_schedule_seq_if.slave ks
);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_q;
  logic [63:0] round_key_q;
  logic [3:0]  round_number_q;
  logic [3:0]  rcon_q;
  logic        key_valid_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] w0, w1, w2, w3;
  logic [15:0] rot_w3, sub_w3, t_w;
  logic [15:0] n0, n1, n2, n3;
  logic [63:0] round_key_d;
  logic [3:0]  rcon_d;

  assign w0 = round_key_q[63:48];
  assign w1 = round_key_q[47:32];
  assign w2 = round_key_q[31:16];
  assign w3 = round_key_q[15:0];

  assign rot_w3 = {w3[11:0], w3[15:12]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      key_schedule_seq_sbox u_sbox (
        .nib_i (rot_w3[4*gi +: 4]),
        .nib_o (sub_w3[4*gi +: 4])
      );
    end
  endgenerate

  assign t_w = sub_w3 ^ {rcon_q, 12'h000};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign round_key_d = {n0, n1, n2, n3};

  // GF(2^4) doubling modulo x^4+x+1
  assign rcon_d = {rcon_q[2:0], 1'b0} ^ (rcon_q[3] ? 4'h3 : 4'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      round_key_q    <= 64'h0;
      round_number_q <= 4'h0;
      rcon_q         <= 4'h1;
      key_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ks.start) begin
            round_key_q    <= ks.key_in;
            round_number_q <= 4'h0;
            rcon_q         <= 4'h1;
            key_valid_q    <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= EMIT;
          end
        end
        EMIT: begin
          if (key_valid_q && ks.key_ready) begin
            if (round_number_q == LAST_ROUND) begin
              key_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end else begin
              round_key_q    <= round_key_d;
              round_number_q <= round_number_q + 4'h1;
              rcon_q         <= rcon_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ks.key_valid    = key_valid_q;
  assign ks.round_key    = round_key_q;
  assign ks.round_number = round_number_q;
  assign ks.busy         = busy_q;
  assign ks.done         = done_q;
endmodule
